// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte and status pulses out.
interface uart_rx_if;
    logic       uart_rxd;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (input uart_rxd, output dout, valid, frame_err, busy);
    modport slave  (output uart_rxd, input dout, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit sampling FSM, registered
// one-cycle valid / frame_err pulses and a break-wait state for held-low lines.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rxd_s;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_shreg;
    logic [7:0]    w_shreg_next;
    logic [7:0]    r_dout;
    logic [7:0]    w_dout_next;
    logic          r_valid;
    logic          w_valid_next;
    logic          r_frame_err;
    logic          w_ferr_next;
    logic          r_busy;

    assign w_rxd_s = r_sync2;

    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_dout      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shreg     <= w_shreg_next;
            r_dout      <= w_dout_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_ferr_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Next-state and datapath decode; counters clear on every state change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_shreg_next = r_shreg;
        w_dout_next  = r_dout;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                if (!w_rxd_s) begin
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF_M1) begin
                    w_cnt_next = '0;
                    w_bit_next = 3'd0;
                    // A line back high at mid start bit was a glitch.
                    if (w_rxd_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_next   = '0;
                    w_shreg_next = {w_rxd_s, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_next = '0;
                    if (w_rxd_s) begin
                        w_dout_next  = r_shreg;
                        w_valid_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_BRK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_BRK: begin
                w_cnt_next = '0;
                if (w_rxd_s) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_BRK;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_bit_next   = 3'd0;
            end
        endcase
    end

    assign bus.dout      = r_dout;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are serialised here and every expected
// pulse is predicted from the frame start edge by plain latency arithmetic.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_dout = 8'h00;
    int         exp16_cyc = 0;
    int         seen16 = 0;

    uart_rx_if if8 ();
    uart_rx_if if16 ();

    uart_rx #(.CLKS_PER_BIT(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    // Edge counter: after rising edge N has occurred, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_line(input bit sel16, input logic v);
        if (sel16) if16.uart_rxd = v;
        else       if8.uart_rxd  = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle8(input int n);
        if8.uart_rxd = 1'b1;
        wait_cyc(n);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Caller is positioned #1 after a rising edge; the next edge is E0.
    task automatic send_frame(input bit sel16, input logic [7:0] b, input logic stop, input bit push);
        int         cpb;
        int         e0;
        logic [9:0] bits;
        cpb  = sel16 ? 16 : 8;
        bits = {stop, b, 1'b0};
        e0   = cyc + 1;
        if (push) exp_q.push_back('{e0 + 2 + cpb / 2 + 9 * cpb, !stop, b});
        if (sel16) exp16_cyc = e0 + 2 + cpb / 2 + 9 * cpb;
        for (int i = 0; i < 10; i++) begin
            set_line(sel16, bits[i]);
            wait_cyc(cpb);
        end
    endtask

    // Scoreboard for the 8-clock instance: every pulse must match the next prediction.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check_eq("missed_pulse", 32'(exp_q[0].cyc), 32'(cyc));
            void'(exp_q.pop_front());
        end
        if (if8.valid || if8.frame_err) begin
            check_eq("pulse_exclusive", {31'd0, if8.valid & if8.frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, if8.valid, if8.frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check_eq("pulse_kind", {30'd0, if8.valid, if8.frame_err},
                         e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) model_dout = e.data;
                check_eq("dout", {24'd0, if8.dout}, {24'd0, model_dout});
            end
        end
    end

    // Observer for the 16-clock instance.
    always @(negedge clk) begin
        if (if16.valid || if16.frame_err) begin
            seen16++;
            check_eq("p16_cycle", 32'(cyc), 32'(exp16_cyc));
            check_eq("p16_kind", {30'd0, if16.valid, if16.frame_err}, 32'd2);
            check_eq("p16_dout", {24'd0, if16.dout}, 32'h81);
        end
    end

    initial begin
        int          e0;
        logic [7:0]  b;
        bit          bad;
        if8.uart_rxd  = 1'b1;
        if16.uart_rxd = 1'b1;
        #1;
        check_eq("rst_dout",  {24'd0, if8.dout}, 32'd0);
        check_eq("rst_valid", {31'd0, if8.valid}, 32'd0);
        check_eq("rst_ferr",  {31'd0, if8.frame_err}, 32'd0);
        check_eq("rst_busy",  {31'd0, if8.busy}, 32'd0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);

        send_frame(1'b0, 8'hA5, 1'b1, 1'b1);
        idle8(10);

        // Reset while in the data bits: everything returns to reset values, no pulse.
        if8.uart_rxd = 1'b0;
        wait_cyc(30);
        check_eq("busy_mid_frame", {31'd0, if8.busy}, 32'd1);
        rst = 1'b1;
        model_dout = 8'h00;
        #1;
        check_eq("rstmid_dout",  {24'd0, if8.dout}, 32'd0);
        check_eq("rstmid_valid", {31'd0, if8.valid}, 32'd0);
        check_eq("rstmid_ferr",  {31'd0, if8.frame_err}, 32'd0);
        check_eq("rstmid_busy",  {31'd0, if8.busy}, 32'd0);
        if8.uart_rxd = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(100);
        check_eq("busy_after_rst", {31'd0, if8.busy}, 32'd0);

        // Back-to-back frames with no gap between stop and next start.
        send_frame(1'b0, 8'h00, 1'b1, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b1, 1'b1);
        send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
        idle8(20);

        // Two-clock low glitch on an idle line.
        e0 = cyc + 1;
        if8.uart_rxd = 1'b0;
        wait_cyc(2);
        if8.uart_rxd = 1'b1;
        at_cyc(e0 + 2);
        check_eq("glitch_busy_hi", {31'd0, if8.busy}, 32'd1);
        at_cyc(e0 + 2 + 4);
        check_eq("glitch_busy_lo", {31'd0, if8.busy}, 32'd0);
        @(posedge clk);
        #1;
        idle8(20);

        // Bad stop bit followed by a held-low break.
        send_frame(1'b0, 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(10);
            check_eq("brk_busy", {31'd0, if8.busy}, 32'd1);
        end
        if8.uart_rxd = 1'b1;
        wait_cyc(4);
        check_eq("brk_release_busy", {31'd0, if8.busy}, 32'd0);
        idle8(10);

        // Random frames, random gaps, occasional bad stop bits.
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(1'b0, b, !bad, 1'b1);
            if (bad) begin
                wait_cyc($urandom_range(0, 10));
                idle8($urandom_range(2, 6));
            end else begin
                idle8($urandom_range(0, 5));
            end
        end
        idle8(100);

        send_frame(1'b1, 8'h81, 1'b1, 1'b0);
        wait_cyc(40);

        check_eq("pending_pulses", 32'(exp_q.size()), 32'd0);
        check_eq("p16_count", 32'(seen16), 32'd1);
        check_eq("final_dout", {24'd0, if8.dout}, {24'd0, model_dout});
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver paired with the existing UART transmitter. It consumes the transmitter's serial line (or an external RXD pin) and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. Each byte goes to the local sink with a one-cycle valid pulse. Bit period matches the transmitter (CLKS_PER_BIT clocks per bit), so the two blocks can be looped back directly.

Parameters:
CLKS_PER_BIT, 8, clocks per serial bit; must be ≥4 and even.
HALF_BIT, CLKS_PER_BIT/2, clocks from start-bit detect to start-bit mid-sample.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
uart_rxd  input  1  serial line, idle high, asynchronous to clk
dout  output  8  last correctly received byte
valid  output  1  one-cycle pulse, dout updated this cycle
frame_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, rst=1) forces: dout=8'h00, valid=0, frame_err=0, busy=0.
  - Internal reset: state=IDLE, counters=0, shift register=0, both synchroniser flops=1.
  - Reset mid-frame abandons the frame with no pulse.
- Input synchroniser: 2 flops on uart_rxd produce rxd_s. The FSM uses only rxd_s.
- Counters:
  - cnt has width clog2(CLKS_PER_BIT) and counts 0..CLKS_PER_BIT-1.
  - bit_idx is 3 bits.
  - Both are cleared on every state change.
- FSM states:
  - IDLE: if rxd_s=0, go to START, cnt=0.
  - START: cnt increments. When cnt==HALF_BIT-1, sample rxd_s.
    - If rxd_s=1 (glitch/false start): go to IDLE, no pulse.
    - Else: go to DATA, cnt=0, bit_idx=0.
  - DATA: cnt increments. When cnt==CLKS_PER_BIT-1, shift rxd_s into shreg MSB (shreg <= {rxd_s, shreg[7:1]}) and cnt=0.
    - bit_idx increments after each sample.
    - After the sample with bit_idx==7, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rxd_s.
    - If rxd_s=1: dout<=shreg, valid<=1, go to IDLE.
    - If rxd_s=0: frame_err<=1, dout unchanged, go to BRK_WAIT.
  - BRK_WAIT: stay until rxd_s=1, then go to IDLE. This prevents a held-low break from retriggering.
- Latency: let E0 be the first clk edge where uart_rxd is low.
  - FSM leaves IDLE at E0+2.
  - Data bit k (k=0..7) is sampled at E0+2+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop bit is sampled at E0+2+HALF_BIT+9*CLKS_PER_BIT.
  - valid/frame_err are high for exactly the cycle after that edge. Defaults: sample at E0+78, pulse in cycle E0+78..E0+79.
- Back-to-back frames: a start edge arriving directly after the stop bit is accepted. IDLE is re-entered the same edge the pulse is registered, so there is zero dead time beyond the half-bit.
- No flow control: dout holds until the next valid frame; the sink must capture it on valid.
- busy=1 in START, DATA, STOP and BRK_WAIT; it is registered from the state.
- valid and frame_err are never high simultaneously.

Test Plan:
- Reset with uart_rxd=1: dout=00, valid=0, frame_err=0, busy=0. Assert rst mid-DATA: all outputs return to reset values and no pulse follows.
- Drive frame 0xA5 (LSB first: 1,0,1,0,0,1,0,1), stop=1, defaults: valid pulses exactly one cycle at E0+78..79 with dout=A5; frame_err stays 0.
- Loopback with the UART transmitter, sending 0x00, 0xFF, 0x3C back-to-back: three valid pulses, dout sequence 00, FF, 3C.
- Low glitch of 2 clocks on an idle line: busy pulses high, returns to IDLE at the start mid-sample, no valid/frame_err.
- Frame 0x55 with stop bit=0: frame_err pulses one cycle, valid=0, dout keeps the previous byte. Line held low 40 more clocks: busy stays 1 and no new frame. Line released to 1: busy drops.
- CLKS_PER_BIT=16, frame 0x81: sample at E0+2+8+144=E0+154, dout=81.
